// File: rtl/clks_alot_lock_controller.sv
// Lock-in sequencer: band-checks each half-period measurement, counts consecutive in-band samples, tracks lock.
// Latency: 1 cycle from an accepted sample (or control change) to updated state/outputs; all outputs registered.
// Backpressure: none; every rate_valid_i pulse is consumed or deliberately ignored (IDLE, HOLD, pause).
module clks_alot_lock_controller #(
   parameter int RATE_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              enable_i,
   input  logic              clear_i,
   input  logic              lockin_en_i,
   input  logic              even_50_50_en_i,
   input  logic              pause_active_i,
   input  logic              rate_valid_i,
   input  logic              rate_is_high_i,
   input  logic [RATE_W-1:0] rate_i,
   input  logic [RATE_W-1:0] hi_min_m1_i,
   input  logic [RATE_W-1:0] hi_max_m1_i,
   input  logic [RATE_W-1:0] lo_min_m1_i,
   input  logic [RATE_W-1:0] lo_max_m1_i,
   input  logic [RATE_W-1:0] lockin_dur_i,
   output logic [1:0]        state_o,
   output logic              locked_o,
   output logic [RATE_W-1:0] inband_cnt_o,
   output logic              violation_o,
   output logic              over_freq_o,
   output logic              under_freq_o,
   output logic              lock_lost_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACQ  = 2'd1,
      ST_LOCK = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   state_t            state_q;
   logic              locked_q;
   logic [RATE_W-1:0] cnt_q;
   logic              viol_q;
   logic              over_q;
   logic              under_q;
   logic              lost_q;

   // Band limits chosen for this sample; all compares are one bit wider so
   // that max_m1 = all-ones still yields a meaningful max_m1 + 1.
   logic [RATE_W-1:0] min_m1;
   logic [RATE_W-1:0] max_m1;
   logic [RATE_W:0]   rate_x;
   logic [RATE_W:0]   min_x;
   logic [RATE_W:0]   max_p1_x;
   logic              is_over;
   logic              is_under;
   logic              in_band;

   // Lock-in duration bookkeeping.
   logic [RATE_W-1:0] dur_eff;
   logic [RATE_W:0]   cnt_p1_x;
   logic [RATE_W-1:0] cnt_inc;
   logic              dur_met;

   // Select limits and classify the presented measurement.
   always_comb begin
      min_m1   = hi_min_m1_i;
      max_m1   = hi_max_m1_i;
      if (!rate_is_high_i && !even_50_50_en_i) begin
         min_m1 = lo_min_m1_i;
         max_m1 = lo_max_m1_i;
      end
      rate_x   = {1'b0, rate_i};
      min_x    = {1'b0, min_m1};
      max_p1_x = {1'b0, max_m1} + (RATE_W+1)'(1);
      is_over  = (rate_x <= min_x);
      // Over wins if the limits are misconfigured so the flags stay exclusive.
      is_under = !is_over && (rate_x > max_p1_x);
      in_band  = !is_over && !is_under;
   end

   // Effective duration (zero treated as one) and saturating count increment.
   always_comb begin
      dur_eff  = lockin_en_i ? lockin_dur_i : RATE_W'(1);
      if (dur_eff == '0) begin
         dur_eff = RATE_W'(1);
      end
      cnt_p1_x = {1'b0, cnt_q} + (RATE_W+1)'(1);
      cnt_inc  = (&cnt_q) ? cnt_q : cnt_p1_x[RATE_W-1:0];
      dur_met  = (cnt_p1_x >= {1'b0, dur_eff});
   end

   // Lock FSM with registered status outputs and one-cycle event pulses.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         locked_q <= 1'b0;
         cnt_q    <= '0;
         viol_q   <= 1'b0;
         over_q   <= 1'b0;
         under_q  <= 1'b0;
         lost_q   <= 1'b0;
      end else begin
         viol_q  <= 1'b0;
         over_q  <= 1'b0;
         under_q <= 1'b0;
         lost_q  <= 1'b0;
         if (clear_i || !enable_i) begin
            state_q  <= ST_IDLE;
            locked_q <= 1'b0;
            cnt_q    <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  state_q  <= ST_ACQ;
                  locked_q <= 1'b0;
                  cnt_q    <= '0;
               end
               ST_ACQ: begin
                  if (pause_active_i) begin
                     cnt_q <= '0;
                  end else if (rate_valid_i) begin
                     if (in_band) begin
                        cnt_q <= cnt_inc;
                        if (dur_met) begin
                           state_q  <= ST_LOCK;
                           locked_q <= 1'b1;
                        end
                     end else begin
                        cnt_q   <= '0;
                        viol_q  <= 1'b1;
                        over_q  <= is_over;
                        under_q <= is_under;
                     end
                  end
               end
               ST_LOCK: begin
                  // A pause outranks a coincident sample: the sample is dropped.
                  if (pause_active_i) begin
                     state_q <= ST_HOLD;
                  end else if (rate_valid_i) begin
                     if (in_band) begin
                        cnt_q <= cnt_inc;
                     end else begin
                        state_q  <= ST_ACQ;
                        locked_q <= 1'b0;
                        cnt_q    <= '0;
                        viol_q   <= 1'b1;
                        over_q   <= is_over;
                        under_q  <= is_under;
                        lost_q   <= 1'b1;
                     end
                  end
               end
               ST_HOLD: begin
                  if (!pause_active_i) begin
                     state_q <= ST_LOCK;
                  end
               end
               default: begin
                  state_q  <= ST_IDLE;
                  locked_q <= 1'b0;
                  cnt_q    <= '0;
               end
            endcase
         end
      end
   end

   assign state_o      = state_q;
   assign locked_o     = locked_q;
   assign inband_cnt_o = cnt_q;
   assign violation_o  = viol_q;
   assign over_freq_o  = over_q;
   assign under_freq_o = under_q;
   assign lock_lost_o  = lost_q;

endmodule
